// File: rtl/audio_frame_buffer_if.sv
// Sample-in / frame-out bundle between the codec side, the frame buffer and the FFT stage.
// The master side drives samples and fft_ready; the slave side is the buffer.
interface audio_frame_buffer_if #(
  parameter int DATA_W = 16
);
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              fft_ready;
  logic              isready;
  logic [DATA_W-1:0] audio_output;
  logic              overflow;
  logic              frame_done;

  modport master (
    output sample_valid, sample_in, fft_ready,
    input  isready, audio_output, overflow, frame_done
  );

  modport slave (
    input  sample_valid, sample_in, fft_ready,
    output isready, audio_output, overflow, frame_done
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer: collects codec samples into two FRAME_LEN banks and replays
// each completed bank to the FFT as one unbroken FRAME_LEN-cycle burst.
module audio_frame_buffer #(
  parameter int FRAME_LEN = 512,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16
) (
  input logic                clk,
  input logic                reset_n,
  audio_frame_buffer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, GAP} rd_state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // Bank select is the address MSB.
  logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];
  logic [DATA_W-1:0] mem_q;
  logic [ADDR_W:0]   rd_addr;

  rd_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] rd_cnt_reg, rd_cnt_next;
  logic              rd_bank_reg, rd_bank_next;
  logic              clear_full;
  logic              load_out;
  logic              last_beat;

  logic [ADDR_W-1:0] wr_addr_reg;
  logic              wr_bank_reg;
  logic              writable;
  logic              wr_en;
  logic              wr_last;

  logic [1:0]        full_reg, full_next;
  logic              overflow_reg;
  logic [DATA_W-1:0] audio_output_reg;

  assign last_beat = (state_reg == STREAM) && (rd_cnt_reg == LAST_ADDR);

  // A full bank may be refilled in the cycle its final word is being streamed:
  // the incoming sample lands in word 0, which was consumed long ago.
  assign writable = !full_reg[wr_bank_reg] || (last_beat && (rd_bank_reg == wr_bank_reg));
  assign wr_en    = bus.sample_valid && writable;
  assign wr_last  = wr_en && (wr_addr_reg == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_reg, wr_addr_reg}] <= bus.sample_in;
    end
    mem_q <= mem[rd_addr];
  end

  always_comb begin
    state_next   = state_reg;
    rd_cnt_next  = rd_cnt_reg;
    rd_bank_next = rd_bank_reg;
    clear_full   = 1'b0;
    load_out     = 1'b0;
    rd_addr      = {rd_bank_reg, rd_cnt_reg + ADDR_W'(2)};
    case (state_reg)
      IDLE: begin
        rd_addr = {rd_bank_reg, {ADDR_W{1'b0}}};
        if (full_reg[rd_bank_reg] && bus.fft_ready) begin
          state_next = PRIME;
        end
      end
      PRIME: begin
        rd_addr     = {rd_bank_reg, ADDR_W'(1)};
        rd_cnt_next = '0;
        load_out    = 1'b1;
        state_next  = STREAM;
      end
      STREAM: begin
        // Reads run two words ahead to cover RAM plus output-register latency.
        rd_cnt_next = rd_cnt_reg + ADDR_W'(1);
        if (rd_cnt_reg == LAST_ADDR) begin
          clear_full   = 1'b1;
          rd_bank_next = ~rd_bank_reg;
          state_next   = GAP;
        end else begin
          load_out = 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    always_comb begin
      full_next[gi] = full_reg[gi];
      if (clear_full && (rd_bank_reg == 1'(gi))) begin
        full_next[gi] = 1'b0;
      end
      if (wr_last && (wr_bank_reg == 1'(gi))) begin
        full_next[gi] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      rd_cnt_reg       <= '0;
      rd_bank_reg      <= 1'b0;
      wr_bank_reg      <= 1'b0;
      wr_addr_reg      <= '0;
      full_reg         <= '0;
      overflow_reg     <= 1'b0;
      audio_output_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rd_cnt_reg  <= rd_cnt_next;
      rd_bank_reg <= rd_bank_next;
      full_reg    <= full_next;
      if (wr_en) begin
        wr_addr_reg <= wr_addr_reg + ADDR_W'(1);
        if (wr_last) begin
          wr_bank_reg <= ~wr_bank_reg;
        end
      end
      if (bus.sample_valid && !writable) begin
        overflow_reg <= 1'b1;
      end
      if (load_out) begin
        audio_output_reg <= mem_q;
      end
    end
  end

  assign bus.isready      = (state_reg == STREAM);
  assign bus.frame_done   = (state_reg == GAP);
  assign bus.audio_output = audio_output_reg;
  assign bus.overflow     = overflow_reg;

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: a scoreboard queue holds every sample expected
// to come back out, and a negedge monitor pops it against each burst beat.
module tb_audio_frame_buffer;
  localparam int FRAME_LEN = 512;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  audio_frame_buffer_if #(.DATA_W(DATA_W)) bus();

  audio_frame_buffer #(
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [DATA_W-1:0] sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int bursts   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents one sample in the current cycle, then idles; entry and exit are at posedge+1.
  task automatic drive(input int v, input bit push, input int idle);
    bus.sample_valid = 1'b1;
    bus.sample_in    = DATA_W'(v);
    if (push) sb.push_back(DATA_W'(v));
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.isready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.sample_valid = 1'b0;
    sb.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
  endtask

  // Monitor: burst data, burst length and frame_done placement.
  initial begin
    bit prev = 1'b0;
    int blen = 0;
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        blen = 0;
      end else begin
        check("frame_done", 32'(bus.frame_done), 32'(prev && !bus.isready));
        if (bus.isready) begin
          blen++;
          exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 32'hFFFF_FFFF;
          check("audio_output", 32'(bus.audio_output), exp);
        end else if (prev) begin
          check("burst_len", 32'(blen), 32'(FRAME_LEN));
          bursts++;
          blen = 0;
        end
        prev = bus.isready;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.fft_ready    = 1'b1;

    // Test 1: reset state, slow input, latency.
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_isready", 32'(bus.isready), 32'd0);
    check("rst_audio_output", 32'(bus.audio_output), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < FRAME_LEN; i++) drive(i, 1'b1, (i == FRAME_LEN - 1) ? 0 : 3);
    @(negedge clk);
    check("t1_lat_n1", 32'(bus.isready), 32'd0);
    @(negedge clk);
    check("t1_lat_n2", 32'(bus.isready), 32'd0);
    @(negedge clk);
    check("t1_lat_n3", 32'(bus.isready), 32'd1);
    @(posedge clk); #1;
    drain(3000);
    check("t1_bursts", 32'(bursts), 32'd1);
    check("t1_overflow", 32'(bus.overflow), 32'd0);

    // Test 2: 2048 samples at full rate with a short pause after each frame.
    base = bursts;
    for (int i = 0; i < 4 * FRAME_LEN; i++) drive(i, 1'b1, (i % FRAME_LEN == FRAME_LEN - 1) ? 4 : 0);
    drain(3000);
    check("t2_bursts", 32'(bursts), 32'(base + 4));
    check("t2_overflow", 32'(bus.overflow), 32'd0);

    // Test 4: fft_ready drops 100 cycles into a burst.
    base = bursts;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (i == 614) bus.fft_ready = 1'b0;
      drive(16'h4000 + i, 1'b1, 0);
    end
    repeat (300) begin
      @(posedge clk); #1;
    end
    check("t4_held_isready", 32'(bus.isready), 32'd0);
    check("t4_held_bursts", 32'(bursts), 32'(base + 1));
    bus.fft_ready = 1'b1;
    drain(3000);
    check("t4_bursts", 32'(bursts), 32'(base + 2));

    // Test 3: both banks full, one sample too many.
    base = bursts;
    bus.fft_ready = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) drive(i, 1'b1, 0);
    check("t3_ovf_before", 32'(bus.overflow), 32'd0);
    drive(16'hABCD, 1'b0, 0);
    check("t3_ovf_after", 32'(bus.overflow), 32'd1);
    check("t3_no_burst", 32'(bursts), 32'(base));
    check("t3_isready", 32'(bus.isready), 32'd0);
    bus.fft_ready = 1'b1;
    drain(3000);
    check("t3_bursts", 32'(bursts), 32'(base + 2));
    check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);

    // Test 5: reset during a burst.
    for (int i = 0; i < FRAME_LEN; i++) drive(16'h1000 + i, 1'b1, 0);
    n = 0;
    while (!bus.isready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_burst_start", 32'(bus.isready), 32'd1);
    repeat (200) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("t5_isready_after_rst", 32'(bus.isready), 32'd0);
    check("t5_overflow_after_rst", 32'(bus.overflow), 32'd0);
    base = bursts;
    for (int i = 0; i < FRAME_LEN; i++) drive(16'h2000 + i, 1'b1, 0);
    drain(3000);
    check("t5_bursts", 32'(bursts), 32'(base + 1));
    check("t5_overflow", 32'(bus.overflow), 32'd0);

    // Test 6: first word of a refill lands in bank 0's final STREAM cycle (cycle 1113).
    bus.fft_ready = 1'b0;
    do_reset();
    base = bursts;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      if (i == 600) bus.fft_ready = 1'b1;
      drive(16'h3000 + i, 1'b1, 0);
    end
    repeat (89) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < FRAME_LEN; i++) drive(16'h3400 + i, 1'b1, 0);
    check("t6_ovf_after_refill", 32'(bus.overflow), 32'd0);
    drain(3000);
    check("t6_bursts", 32'(bursts), 32'(base + 3));
    check("t6_overflow", 32'(bus.overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
